// File: rtl/lfsr_burst_arbiter.sv
// Round-robin arbiter sharing one LFSR core among burst requesters.
// Sequences core enable/load strobes and streams words with backpressure.
module lfsr_burst_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int LEN_W   = 4,
  parameter int DATA_W  = 8,
  localparam int ID_W   = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*LEN_W-1:0] req_len,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic                     cfg_load_valid,
  input  logic [DATA_W-1:0]        cfg_seed,
  output logic                     cfg_load_ready,
  output logic                     core_enable,
  output logic                     core_load,
  output logic [DATA_W-1:0]        core_seed,
  input  logic [DATA_W-1:0]        core_data,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_W-1:0]        rsp_data,
  output logic [ID_W-1:0]          rsp_id,
  output logic                     rsp_last,
  output logic                     busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_BURST
  } state_t;

  localparam logic [ID_W:0]   NR   = (ID_W+1)'(NUM_REQ);
  localparam logic [ID_W-1:0] LAST = ID_W'(NUM_REQ - 1);

  state_t            r_state;
  logic [ID_W-1:0]   r_ptr;
  logic [ID_W-1:0]   r_owner;
  logic [LEN_W-1:0]  r_count;
  logic [DATA_W-1:0] r_seed;

  logic [2*NUM_REQ-1:0] w_rot;
  logic                 w_any;
  logic [ID_W-1:0]      w_off;
  logic [ID_W:0]        w_sum;
  logic [ID_W:0]        w_wrap;
  logic [ID_W-1:0]      w_win;
  logic [LEN_W-1:0]     w_len;
  logic [ID_W-1:0]      w_ptr_nxt;
  logic                 w_idle;
  logic                 w_burst;
  logic                 w_grant;

  // Rotate so bit 0 is the requester at r_ptr; lowest set bit wins.
  assign w_rot = {req_valid, req_valid} >> r_ptr;

  always_comb begin
    w_any = 1'b0;
    w_off = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_any = 1'b1;
        w_off = ID_W'(k);
      end
    end
  end

  assign w_sum  = {1'b0, r_ptr} + {1'b0, w_off};
  assign w_wrap = w_sum - NR;
  assign w_win  = (w_sum >= NR) ? w_wrap[ID_W-1:0]
                                : w_sum[ID_W-1:0];
  assign w_len  = req_len[w_win*LEN_W +: LEN_W];

  assign w_ptr_nxt = (r_owner == LAST) ? '0
                                       : r_owner + 1'b1;

  assign w_idle  = (r_state == S_IDLE);
  assign w_burst = (r_state == S_BURST);
  // Acks are combinational, so gate them while reset is held.
  assign w_grant = rst_n & w_idle & ~cfg_load_valid & w_any;

  assign cfg_load_ready = rst_n & w_idle & cfg_load_valid;
  assign req_ready      = w_grant ? (NUM_REQ'(1) << w_win) : '0;
  assign core_load      = (r_state == S_LOAD);
  assign core_enable    = w_burst & rsp_ready;
  assign core_seed      = r_seed;
  assign rsp_valid      = w_burst;
  assign rsp_data       = w_burst ? core_data : '0;
  assign rsp_id         = w_burst ? r_owner : '0;
  assign rsp_last       = w_burst & (r_count == '0);
  assign busy           = ~w_idle;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_owner <= '0;
      r_count <= '0;
      r_seed  <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (cfg_load_valid) begin
            r_seed  <= cfg_seed;
            r_state <= S_LOAD;
          end else if (w_any) begin
            r_owner <= w_win;
            r_count <= w_len;
            r_state <= S_BURST;
          end
        end
        S_LOAD: r_state <= S_IDLE;
        S_BURST: begin
          if (rsp_ready) begin
            if (r_count == '0) begin
              r_state <= S_IDLE;
              r_ptr   <= w_ptr_nxt;
            end else begin
              r_count <= r_count - 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_burst_arbiter.sv
// Bench for lfsr_burst_arbiter: behavioural core, word-level model,
// per-cycle compare and directed scenarios with literal expectations.
module tb_lfsr_burst_arbiter;

  localparam int N  = 4;
  localparam int LW = 4;
  localparam int DW = 8;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  req_valid = '0;
  logic [N*LW-1:0] req_len = '0;
  logic [N-1:0]  req_ready;
  logic          cfg_load_valid = 1'b0;
  logic [DW-1:0] cfg_seed = '0;
  logic          cfg_load_ready;
  logic          core_enable;
  logic          core_load;
  logic [DW-1:0] core_seed;
  logic [DW-1:0] core_data;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_data;
  logic [IW-1:0] rsp_id;
  logic          rsp_last;
  logic          busy;

  always #5 clk = ~clk;

  lfsr_burst_arbiter #(.NUM_REQ(N), .LEN_W(LW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_len(req_len),
    .req_ready(req_ready),
    .cfg_load_valid(cfg_load_valid), .cfg_seed(cfg_seed),
    .cfg_load_ready(cfg_load_ready),
    .core_enable(core_enable), .core_load(core_load),
    .core_seed(core_seed), .core_data(core_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id),
    .rsp_last(rsp_last), .busy(busy)
  );

  function automatic logic [7:0] step(logic [7:0] v);
    return {v[6:0], ^(v & 8'hB8)};
  endfunction

  // Behavioural LFSR core: reset value 0x19, taps 0xB8.
  logic [DW-1:0] core_q;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) core_q <= 8'h19;
    else if (core_load) core_q <= core_seed;
    else if (core_enable) core_q <= step(core_q);
  end
  assign core_data = core_q;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: phase 0 idle, 1 seed load, 2 streaming words
  int m_phase, m_left, m_owner, m_ptr;
  logic [7:0] m_seed, m_lfsr;
  int n_phase, n_left, n_owner, n_ptr;
  logic [7:0] n_seed, n_lfsr;

  logic [7:0] hs_data[$];
  int hs_id[$];
  int hs_last[$];
  int hs_cyc[$];
  int grants[$];
  int grant_cyc[$];
  int cfg_cyc[$];
  int load_cyc[$];
  int en_count;

  task automatic clear_logs();
    hs_data.delete(); hs_id.delete(); hs_last.delete();
    hs_cyc.delete(); grants.delete(); grant_cyc.delete();
    cfg_cyc.delete(); load_cyc.delete();
    en_count = 0;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_left = 0; m_owner = 0; m_ptr = 0;
      m_seed = 8'h00; m_lfsr = 8'h19;
      n_phase = 0; n_left = 0; n_owner = 0; n_ptr = 0;
      n_seed = 8'h00; n_lfsr = 8'h19;
    end else begin
      m_phase = n_phase; m_left = n_left;
      m_owner = n_owner; m_ptr = n_ptr;
      m_seed = n_seed; m_lfsr = n_lfsr;
    end
  end

  always @(negedge clk) begin
    logic [N-1:0] e_req;
    logic e_cfg, e_en, e_ld, e_rv, e_last, e_busy;
    logic [7:0] e_data, e_seed;
    int e_id, w;
    cyc++;
    e_req = '0; e_cfg = 0; e_en = 0; e_ld = 0; e_rv = 0;
    e_last = 0; e_busy = 0; e_data = '0; e_seed = '0;
    e_id = 0; w = -1;
    n_phase = m_phase; n_left = m_left; n_owner = m_owner;
    n_ptr = m_ptr; n_seed = m_seed; n_lfsr = m_lfsr;
    if (rst_n) begin
      e_seed = m_seed;
      e_busy = (m_phase != 0);
      case (m_phase)
        0: begin
          if (cfg_load_valid) begin
            e_cfg = 1; n_seed = cfg_seed; n_phase = 1;
          end else if (req_valid != '0) begin
            for (int k = 0; k < N; k++)
              if (w < 0 && req_valid[(m_ptr + k) % N])
                w = (m_ptr + k) % N;
            e_req = N'(1) << w;
            n_phase = 2; n_owner = w;
            n_left = int'(req_len[w*LW +: LW]) + 1;
          end
        end
        1: begin
          e_ld = 1; n_lfsr = m_seed; n_phase = 0;
        end
        default: begin
          e_rv = 1; e_data = m_lfsr; e_id = m_owner;
          e_last = (m_left == 1);
          if (rsp_ready) begin
            e_en = 1; n_lfsr = step(m_lfsr);
            n_left = m_left - 1;
            if (n_left == 0) begin
              n_phase = 0; n_ptr = (m_owner + 1) % N;
            end
          end
        end
      endcase
    end
    chk("req_ready", 32'(req_ready), 32'(e_req));
    chk("cfg_load_ready", 32'(cfg_load_ready), 32'(e_cfg));
    chk("core_enable", 32'(core_enable), 32'(e_en));
    chk("core_load", 32'(core_load), 32'(e_ld));
    chk("core_seed", 32'(core_seed), 32'(e_seed));
    chk("rsp_valid", 32'(rsp_valid), 32'(e_rv));
    chk("rsp_data", 32'(rsp_data), 32'(e_data));
    chk("rsp_id", 32'(rsp_id), 32'(e_id));
    chk("rsp_last", 32'(rsp_last), 32'(e_last));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("en_load_overlap", 32'(core_enable & core_load), 0);
    if (rst_n) begin
      if (rsp_valid && rsp_ready) begin
        hs_data.push_back(rsp_data); hs_id.push_back(rsp_id);
        hs_last.push_back(rsp_last); hs_cyc.push_back(cyc);
      end
      for (int i = 0; i < N; i++)
        if (req_ready[i]) begin
          grants.push_back(i); grant_cyc.push_back(cyc);
        end
      if (cfg_load_ready) cfg_cyc.push_back(cyc);
      if (core_load) load_cyc.push_back(cyc);
      if (core_enable) en_count++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0; cfg_load_valid = 1'b0; rsp_ready = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_idle(int budget);
    int n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    chk("idle_timeout", 32'(busy), 0);
  endtask

  int pat[7] = '{1, 0, 0, 1, 1, 0, 1};
  int n;
  int last_hs;

  initial begin
    clear_logs();
    // Reset with every input active: outputs must stay quiet.
    req_valid = '1; cfg_load_valid = 1'b1; rsp_ready = 1'b1;
    repeat (2) tick();
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_cfg_ready", 32'(cfg_load_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_core_load", 32'(core_load), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    do_reset();

    // Single burst from requester 0
    clear_logs();
    req_valid = 4'b0001; req_len = '0; req_len[3:0] = 4'd2;
    rsp_ready = 1'b1;
    tick();
    req_valid = '0;
    wait_idle(20);
    chk("t1_words", hs_data.size(), 3);
    if (hs_data.size() == 3) begin
      chk("t1_w0", hs_data[0], 8'h19);
      chk("t1_w1", hs_data[1], 8'h32);
      chk("t1_w2", hs_data[2], 8'h64);
      chk("t1_last", hs_last[2], 1);
      chk("t1_notlast", hs_last[1], 0);
      chk("t1_id", hs_id[2], 0);
    end
    chk("t1_core_after", core_data, 8'hC9);
    chk("t1_grants", grants.size(), 1);

    // All four requesting, single-word bursts
    do_reset();
    clear_logs();
    req_valid = 4'b1111; req_len = '0; rsp_ready = 1'b1;
    n = 0;
    while (grants.size() < 5 && n < 40) begin
      tick();
      n++;
    end
    req_valid = '0;
    wait_idle(20);
    chk("t2_grants", grants.size(), 5);
    if (grants.size() == 5) begin
      chk("t2_g0", grants[0], 0);
      chk("t2_g1", grants[1], 1);
      chk("t2_g2", grants[2], 2);
      chk("t2_g3", grants[3], 3);
      chk("t2_g4", grants[4], 0);
      chk("t2_gap", grant_cyc[1] - grant_cyc[0], 2);
    end
    chk("t2_words", hs_data.size(), 5);

    // Backpressure on a four-word burst from requester 2
    clear_logs();
    req_valid = 4'b0100; req_len = '0; req_len[11:8] = 4'd3;
    rsp_ready = 1'b0;
    tick();
    req_valid = '0;
    foreach (pat[i]) begin
      rsp_ready = pat[i][0];
      tick();
    end
    rsp_ready = 1'b0;
    chk("t3_busy", 32'(busy), 0);
    chk("t3_words", hs_data.size(), 4);
    chk("t3_enables", en_count, 4);
    if (hs_data.size() == 4) begin
      chk("t3_w0", hs_data[0], 8'h24);
      chk("t3_w3", hs_data[3], 8'h26);
      chk("t3_last", hs_last[3], 1);
      chk("t3_id", hs_id[0], 2);
    end

    // Reload and request in the same idle cycle
    clear_logs();
    cfg_load_valid = 1'b1; cfg_seed = 8'hA5;
    req_valid = 4'b0010; req_len = '0; req_len[7:4] = 4'd1;
    rsp_ready = 1'b1;
    tick();
    cfg_load_valid = 1'b0;
    n = 0;
    while (grants.size() < 1 && n < 10) begin
      tick();
      n++;
    end
    req_valid = '0;
    wait_idle(20);
    chk("t4_cfg", cfg_cyc.size(), 1);
    chk("t4_load", load_cyc.size(), 1);
    chk("t4_grant", grants.size(), 1);
    if (cfg_cyc.size() == 1 && load_cyc.size() == 1 &&
        grants.size() == 1) begin
      chk("t4_load_after_cfg", load_cyc[0] - cfg_cyc[0], 1);
      chk("t4_grant_after_load", grant_cyc[0] - load_cyc[0], 1);
      chk("t4_grant_id", grants[0], 1);
    end
    if (hs_data.size() == 2) begin
      chk("t4_w0", hs_data[0], 8'hA5);
      chk("t4_w1", hs_data[1], 8'h4A);
    end else chk("t4_words", hs_data.size(), 2);

    // Reload raised mid-burst waits for the burst to finish
    clear_logs();
    req_valid = 4'b0010; req_len = '0; req_len[7:4] = 4'd3;
    rsp_ready = 1'b1;
    tick();
    req_valid = '0;
    tick();
    cfg_load_valid = 1'b1; cfg_seed = 8'h00;
    n = 0;
    while (cfg_cyc.size() < 1 && n < 20) begin
      tick();
      n++;
    end
    cfg_load_valid = 1'b0;
    wait_idle(20);
    chk("t5_words", hs_data.size(), 4);
    chk("t5_cfg", cfg_cyc.size(), 1);
    last_hs = hs_cyc.size() > 0 ? hs_cyc[hs_cyc.size()-1] : 0;
    if (cfg_cyc.size() == 1)
      chk("t5_cfg_after_last", 32'(cfg_cyc[0] > last_hs), 1);
    chk("t5_seed_zero", core_data, 8'h00);

    // Reset in the middle of a five-word burst
    clear_logs();
    req_valid = 4'b0100; req_len = '0; req_len[11:8] = 4'd4;
    rsp_ready = 1'b1;
    tick();
    req_valid = '0;
    repeat (2) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rsp_valid", 32'(rsp_valid), 0);
    chk("t6_rsp_data", 32'(rsp_data), 0);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_enable", 32'(core_enable), 0);
    chk("t6_words", hs_data.size(), 2);
    if (hs_last.size() == 2)
      chk("t6_no_last", hs_last[1], 0);
    rsp_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("t6_busy_after", 32'(busy), 0);
    clear_logs();
    req_valid = 4'b1001; rsp_ready = 1'b1;
    tick();
    req_valid = '0;
    wait_idle(20);
    chk("t6_regrant_n", grants.size(), 1);
    if (grants.size() == 1)
      chk("t6_regrant_id", grants[0], 0);

    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/lfsr_burst_arbiter.md
Name: lfsr_burst_arbiter

Overview:
Shares one 8-bit LFSR generator core among NUM_REQ requesters.
- Each requester asks for a burst of pseudo-random words. The block round-robin arbitrates, sequences the core's enable and load strobes, and streams words back with valid/ready backpressure.
- Seed reload requests are serialized between bursts.
- Sits between the register/bus slave and the LFSR core, replacing direct ctrl-register driving of enable/load.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
LEN_W, 4, burst length field width; burst = len+1 words (1..16)
DATA_W, 8, LFSR word width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester burst request
req_len  in  NUM_REQ*LEN_W  flattened lengths; requester i uses bits [i*LEN_W +: LEN_W]
req_ready  out  NUM_REQ  one-hot acceptance pulse
cfg_load_valid  in  1  seed reload request
cfg_seed  in  DATA_W  seed to load
cfg_load_ready  out  1  reload accepted pulse
core_enable  out  1  advance LFSR one step
core_load  out  1  load core with core_seed
core_seed  out  DATA_W  seed to core
core_data  in  DATA_W  current LFSR value (core output register)
rsp_valid  out  1  word available
rsp_ready  in  1  consumer accepts word
rsp_data  out  DATA_W  = core_data while in BURST, else 0
rsp_id  out  $clog2(NUM_REQ)  owner of current burst
rsp_last  out  1  final word of burst
busy  out  1  state != IDLE

Behaviour:
- Async reset: state=IDLE, rr_ptr=0, owner=0, count=0, core_seed=0. All outputs are 0 and stay 0 until rst_n deasserts; first active edge follows.
- State machine: IDLE, LOAD, BURST.
- IDLE, cfg_load_valid=1:
  - Reload has priority over requests.
  - cfg_load_ready=1 combinationally this cycle; latch cfg_seed into core_seed; go to LOAD.
- IDLE, else any req_valid:
  - Winner = first asserted index scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - req_ready[winner]=1 combinationally this cycle; latch owner=winner and count=req_len[winner]; go to BURST.
  - Grant costs one cycle; no data in the grant cycle.
- LOAD: core_load=1 for exactly one cycle, core_enable=0; go to IDLE.
- BURST outputs: rsp_valid=1, rsp_data=core_data, rsp_id=owner, rsp_last=(count==0).
- BURST, on rsp_valid && rsp_ready:
  - core_enable=1 for that cycle; the core shifts at the same edge, so the next word is present the following cycle.
  - Sustains 1 word/cycle.
  - If rsp_last: go to IDLE and set rsp_ready-independent rr_ptr=(owner+1) mod NUM_REQ. Otherwise count decrements.
- BURST, rsp_ready=0: core_enable=0; rsp_data held stable (core holds); rsp_valid stays high (no retraction).
- core_enable and core_load are never asserted together. Both are 0 in IDLE.
- cfg_load_valid during BURST is not accepted until the burst completes and the FSM returns to IDLE. No preemption.
- req_valid deasserting after grant does not abort the burst. req_len is sampled only in the grant cycle.
- Winner's req_valid still high after its burst: rr_ptr has advanced, so other pending requesters are served first. A sole requester is re-granted after one IDLE cycle.
- Seed 0x00 is passed through unchanged; stuck-zero recovery is the core's responsibility.
- rst_n asserted mid-burst: burst is aborted with no rsp_last, and the FSM returns to IDLE with rr_ptr=0.

Test Plan:
- Reset then core default (value 0x19, taps 0xB8); req_valid[0]=1, req_len=2, rsp_ready=1 -> req_ready[0] pulse; next cycles rsp_data 0x19, 0x32, 0x64 with rsp_id=0; rsp_last on 0x64; core then holds 0xC9; busy drops.
- req_valid=4'b1111, len=0 each, rsp_ready=1 -> grants in order 0,1,2,3,0, one word each; each grant is followed by one data cycle.
- Backpressure: burst len=3, rsp_ready toggles 1,0,0,1,1,0,1 -> exactly 4 handshakes; rsp_data constant across stalls; core_enable pulses equal handshakes (4).
- cfg_load_valid with cfg_seed=0xA5 and req_valid[1] in the same IDLE cycle -> cfg_load_ready first, one core_load cycle, then grant to 1; first rsp_data=0xA5.
- cfg_load_valid raised mid-burst -> not acknowledged until after rsp_last; no core_enable/core_load overlap at any cycle.
- rst_n pulsed low mid-burst (after 2 of 5 words) -> all outputs 0 immediately; after release, busy=0 and the next grant starts scan at requester 0.
